music_sequencer: RTL
====================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter NUM_SONGS, default 9, number of selectable songs (2..16).
REQ-002 Parameter BEAT_W, default 12, width of beat index.
REQ-003 Parameter SONG_LEN, default all 112, packed NUM_SONGS x BEAT_W array; beats per song, each 1..2^BEAT_W.
REQ-004 Parameter TEMPO_DIV, default all 2_097_152, packed NUM_SONGS x 32 array; clk cycles per beat, each >= 40.
REQ-005 Parameter DIV_NUM, default 50_000_000, dividend for note divider computation.
REQ-006 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 play_req  input  NUM_SONGS  one-cycle start pulse per song.
REQ-009 loop_en  input  NUM_SONGS  per-song loop mode, sampled at end of song.
REQ-010 pause  input  1  level; freezes beat advance while high.
REQ-011 stop  input  1  one-cycle pulse; abort playback.
REQ-012 tone_l, tone_r  input  32 each  raw frequency (Hz) of active song at beat_idx, supplied by external song ROM mux.
REQ-013 song_id  output  4  index of active song.
REQ-014 beat_idx  output  BEAT_W  current beat of active song.
REQ-015 note_div_l, note_div_r  output  22 each  note_gen divider values.
REQ-016 busy  output  1  high in PLAY or PAUSED.
REQ-017 div_busy  output  1  high while divider computes.
REQ-018 song_end  output  1  one-cycle pulse when last beat of a song completes.

Function
REQ-019 FSM states IDLE, PLAY, PAUSED; IDLE->PLAY on any play_req bit; PLAY->PAUSED while pause=1; PAUSED->PLAY when pause=0; PLAY/PAUSED->IDLE on stop or on non-looped song end.
REQ-020 Simultaneous play_req bits: lowest index wins; others ignored.
REQ-021 play_req in PLAY/PAUSED (any song, including current) preempts: song_id loads winner, beat_idx=0, tempo counter=0, state PLAY, no song_end pulse.
REQ-022 stop has priority over play_req in the same cycle.
REQ-023 Tempo counter increments each PLAY cycle; at TEMPO_DIV[song_id]-1 it clears and beat advances; frozen (not cleared) in PAUSED.
REQ-024 At beat SONG_LEN[song_id]-1 with tick: song_end=1 that cycle; if loop_en[song_id] beat_idx wraps to 0 and PLAY continues, else state IDLE, beat_idx=0.
REQ-025 Every beat_idx load or advance (including start and wrap) starts a divider run; a new start during a run aborts and restarts it.
REQ-026 Divider: two parallel 32-step restoring dividers, DIV_NUM/tone_l and DIV_NUM/tone_r, tone sampled at run start; results written to note_div_l/r exactly 34 cycles after the beat_idx update; div_busy high for cycles 1..34.
REQ-027 tone==0 or quotient > 2^22-1 yields note_div=1 (silence).
REQ-028 note_div_l/r hold last result during run and PAUSED; forced to 1 in IDLE and in the cycle IDLE is entered.

Reset
REQ-029 On rst: state IDLE, song_id=0, beat_idx=0, tempo counter=0, note_div_l=note_div_r=1, busy=0, div_busy=0, song_end=0; divider aborted.
REQ-030 rst mid-playback or mid-divide takes effect immediately; no song_end pulse produced.

Structure
REQ-031 Shared package music_pkg holds state enum, SILENT_DIV=1, DIV_NUM default and song index constants (DONOT_MOVE_x05, x08, x12, x20, KILL, FOOTSTEP, WAYBACK, HAPPY_END).
REQ-032 One sub-module note_divider (single 32/32 restoring divider with start, abort, done, saturate-to-1) instantiated twice.

Verification
REQ-033 TEMPO_DIV[3]=40, SONG_LEN[3]=4; pulse play_req=0x008 -> song_id=3, beat 0,1,2,3 at 40-cycle spacing, song_end once, then IDLE, note_div=1.
REQ-034 Same with loop_en[3]=1 -> beat wraps 3->0, song_end pulses each lap, busy stays 1 until stop.
REQ-035 play_req=0x006 same cycle -> song 1 selected; later play_req=0x100 mid-song -> song_id=8, beat 0, no song_end.
REQ-036 tone_l=440, tone_r=0 -> 34 cycles after beat update note_div_l=113636, note_div_r=1; tone_l=1 -> note_div_l=1.
REQ-037 pause high 100 cycles mid-beat -> beat_idx and tempo count frozen, resume completes beat with remaining cycles; stop and play_req same cycle -> IDLE.
REQ-038 rst asserted during divide -> all outputs at reset values next cycle, song_end stays 0.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: FSM encodings, song
// index names, note-divider defaults and the play-request arbiter.
package music_pkg;

    typedef enum logic [1:0] {StIdle, StPlay, StPaused} seqState_e;
    typedef enum logic [1:0] {DivIdle, DivArm, DivRun, DivFin} divState_e;

    localparam int unsigned NOTE_DIV_W      = 22;
    localparam logic [21:0] SILENT_DIV      = 22'd1;
    localparam int unsigned DIV_NUM_DEFAULT = 50_000_000;

    localparam logic [3:0] DONOT_MOVE_X05 = 4'd0;
    localparam logic [3:0] DONOT_MOVE_X08 = 4'd1;
    localparam logic [3:0] DONOT_MOVE_X12 = 4'd2;
    localparam logic [3:0] DONOT_MOVE_X20 = 4'd3;
    localparam logic [3:0] KILL           = 4'd4;
    localparam logic [3:0] FOOTSTEP       = 4'd5;
    localparam logic [3:0] WAYBACK        = 4'd6;
    localparam logic [3:0] HAPPY_END      = 4'd7;

    // Lowest set bit wins; scanning downwards lets the last hit be the lowest.
    function automatic logic [3:0] lowestIndex(input logic [15:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/note_divider.sv
// 32/32 restoring divider producing a note_gen divider value; one arm cycle lets
// the external tone mux settle before the divisor is sampled.
module note_divider
    import music_pkg::*;
#(
    parameter int unsigned OUT_W = NOTE_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      dividend,
    input  logic [31:0]      divisor,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] quotient
);

    divState_e   stateQ, stateD;
    logic [31:0] remQ, remD;
    logic [31:0] quoQ, quoD;
    logic [31:0] divQ, divD;
    logic [4:0]  cntQ, cntD;
    logic [32:0] shifted;
    logic [32:0] trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= DivIdle;
            remQ   <= '0;
            quoQ   <= '0;
            divQ   <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            remQ   <= remD;
            quoQ   <= quoD;
            divQ   <= divD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        remD    = remQ;
        quoD    = quoQ;
        divD    = divQ;
        cntD    = cntQ;
        shifted = {remQ, quoQ[31]};
        trial   = shifted - {1'b0, divQ};
        if (abort) begin
            stateD = DivIdle;
        end else if (start) begin
            stateD = DivArm;
        end else begin
            case (stateQ)
                DivArm: begin
                    stateD = DivRun;
                    remD   = '0;
                    quoD   = dividend;
                    divD   = divisor;
                    cntD   = '0;
                end
                DivRun: begin
                    // Borrow out of bit 32 means the trial subtraction went negative.
                    if (!trial[32]) begin
                        remD = trial[31:0];
                        quoD = {quoQ[30:0], 1'b1};
                    end else begin
                        remD = shifted[31:0];
                        quoD = {quoQ[30:0], 1'b0};
                    end
                    cntD = cntQ + 5'd1;
                    if (cntQ == 5'd31) stateD = DivFin;
                end
                DivFin:  stateD = DivIdle;
                default: stateD = DivIdle;
            endcase
        end
    end

    always_comb begin
        busy = (stateQ != DivIdle);
        done = (stateQ == DivFin) && !start && !abort;
        if ((divQ == 32'd0) || (quoQ[31:OUT_W] != '0)) begin
            quotient = OUT_W'(1);
        end else begin
            quotient = quoQ[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Song playback sequencer: selects a song, steps its beat index at the song's
// tempo and converts the current tones into note_gen divider values.
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned                 NUM_SONGS = 9,
    parameter int unsigned                 BEAT_W    = 12,
    parameter logic [NUM_SONGS*BEAT_W-1:0] SONG_LEN  = {NUM_SONGS{BEAT_W'(112)}},
    parameter logic [NUM_SONGS*32-1:0]     TEMPO_DIV = {NUM_SONGS{32'd2_097_152}},
    parameter int unsigned                 DIV_NUM   = DIV_NUM_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SONGS-1:0]  play_req,
    input  logic [NUM_SONGS-1:0]  loop_en,
    input  logic                  pause,
    input  logic                  stop,
    input  logic [31:0]           tone_l,
    input  logic [31:0]           tone_r,
    output logic [3:0]            song_id,
    output logic [BEAT_W-1:0]     beat_idx,
    output logic [NOTE_DIV_W-1:0] note_div_l,
    output logic [NOTE_DIV_W-1:0] note_div_r,
    output logic                  busy,
    output logic                  div_busy,
    output logic                  song_end
);

    seqState_e             stateQ, stateD;
    logic [3:0]            songIdQ, songIdD;
    logic [BEAT_W-1:0]     beatQ, beatD;
    logic [31:0]           tempoQ, tempoD;
    logic [NOTE_DIV_W-1:0] noteDivLQ, noteDivRQ;

    logic [15:0]           reqWide;
    logic                  playAny;
    logic [3:0]            winner;
    logic [BEAT_W-1:0]     curLen;
    logic [BEAT_W-1:0]     lastBeat;
    logic [31:0]           curDiv;
    logic                  curLoop;
    logic                  tick;
    logic                  divStart;
    logic                  divAbort;
    logic                  songEnd;

    logic                  busyL, busyR, doneL, doneR;
    logic [NOTE_DIV_W-1:0] quotL, quotR;

    assign reqWide = 16'(play_req);
    assign playAny = |play_req;
    assign winner  = lowestIndex(reqWide);

    always_comb begin
        curLen  = '0;
        curDiv  = '0;
        curLoop = 1'b0;
        for (int i = 0; i < int'(NUM_SONGS); i++) begin
            if (songIdQ == 4'(i)) begin
                curLen  = SONG_LEN[i*BEAT_W +: BEAT_W];
                curDiv  = TEMPO_DIV[i*32 +: 32];
                curLoop = loop_en[i];
            end
        end
    end

    // A length of 2^BEAT_W encodes as zero, so the wrap-around gives all ones.
    assign lastBeat = curLen - BEAT_W'(1);
    assign tick     = (tempoQ == curDiv - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StIdle;
            songIdQ <= DONOT_MOVE_X05;
            beatQ   <= '0;
            tempoQ  <= '0;
        end else begin
            stateQ  <= stateD;
            songIdQ <= songIdD;
            beatQ   <= beatD;
            tempoQ  <= tempoD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        songIdD  = songIdQ;
        beatD    = beatQ;
        tempoD   = tempoQ;
        divStart = 1'b0;
        songEnd  = 1'b0;
        case (stateQ)
            StIdle: begin
                if (!stop && playAny) begin
                    stateD   = StPlay;
                    songIdD  = winner;
                    beatD    = '0;
                    tempoD   = '0;
                    divStart = 1'b1;
                end
            end
            StPlay, StPaused: begin
                if (stop) begin
                    stateD = StIdle;
                    beatD  = '0;
                    tempoD = '0;
                end else if (playAny) begin
                    stateD   = StPlay;
                    songIdD  = winner;
                    beatD    = '0;
                    tempoD   = '0;
                    divStart = 1'b1;
                end else if (stateQ == StPaused) begin
                    if (!pause) stateD = StPlay;
                end else begin
                    // The cycle that sees pause rise is still a PLAY cycle and counts.
                    stateD = pause ? StPaused : StPlay;
                    if (tick) begin
                        tempoD = '0;
                        beatD  = '0;
                        if (beatQ == lastBeat) begin
                            songEnd = 1'b1;
                            if (curLoop) begin
                                divStart = 1'b1;
                            end else begin
                                stateD = StIdle;
                            end
                        end else begin
                            beatD    = beatQ + BEAT_W'(1);
                            divStart = 1'b1;
                        end
                    end else begin
                        tempoD = tempoQ + 32'd1;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign divAbort = (stateD == StIdle);

    note_divider #(
        .OUT_W    (NOTE_DIV_W)
    ) u_div_l (
        .clk      (clk),
        .rst      (rst),
        .start    (divStart),
        .abort    (divAbort),
        .dividend (32'(DIV_NUM)),
        .divisor  (tone_l),
        .busy     (busyL),
        .done     (doneL),
        .quotient (quotL)
    );

    note_divider #(
        .OUT_W    (NOTE_DIV_W)
    ) u_div_r (
        .clk      (clk),
        .rst      (rst),
        .start    (divStart),
        .abort    (divAbort),
        .dividend (32'(DIV_NUM)),
        .divisor  (tone_r),
        .busy     (busyR),
        .done     (doneR),
        .quotient (quotR)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noteDivLQ <= SILENT_DIV;
            noteDivRQ <= SILENT_DIV;
        end else if (stateD == StIdle) begin
            noteDivLQ <= SILENT_DIV;
            noteDivRQ <= SILENT_DIV;
        end else begin
            if (doneL) noteDivLQ <= quotL;
            if (doneR) noteDivRQ <= quotR;
        end
    end

    assign song_id    = songIdQ;
    assign beat_idx   = beatQ;
    assign note_div_l = noteDivLQ;
    assign note_div_r = noteDivRQ;
    assign busy       = (stateQ != StIdle);
    assign div_busy   = busyL | busyR;
    assign song_end   = songEnd;

endmodule
